stall_sched: RTL and testbench
==============================

# stall_sched

Pipeline stall/flush scheduler for the 5-stage core. Merges per-stage stall requests into one priority-resolved `stall` vector. Sequences multi-cycle EX operations (mult/div) with an internal cycle counter. Defers exception flushes until an in-flight data-bus access completes, then issues a single-cycle flush with the handler PC.

## Interface
- `StallBus`, 6: stall vector width; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `CntW`, 6: width of the multi-cycle length field.

- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low (0 = reset).
- `stallreq_if` in 1: instruction bus not ready.
- `stallreq_id` in 1: load-use hazard.
- `stallreq_ex` in 1: generic EX stall not covered by the counter.
- `stallreq_mem` in 1: data bus access in flight.
- `ex_multi_start` in 1: EX issues a multi-cycle op this cycle.
- `ex_multi_cycles` in CntW: op length N.
- `excp_valid` in 1: exception committed at MEM.
- `excp_new_pc` in 32: handler address.
- `stall` out StallBus: per-stage hold vector.
- `flush` out 1: clear all pipeline registers.
- `new_pc` out 32: redirect PC, valid when `flush`=1.
- `ex_multi_busy` out 1: counter running.
- `ex_multi_done` out 1: one-cycle pulse, EX result ready.

## Operation
- States: `IDLE`, `MULTI` (counter active), `FLUSH_WAIT` (exception latched, waiting on MEM).
- Stall resolution is combinational from inputs and registered state. Priority is highest stage first:
  - flush → `00_0000`
  - `stallreq_mem` → `01_1111`
  - `stallreq_ex` or `ex_multi_busy` → `00_1111`
  - `stallreq_id` → `00_0111`
  - `stallreq_if` → `00_0011`
  - none → `00_0000`
- Multi-cycle start:
  - Accepted only in `IDLE`, with no flush and no `stallreq_mem`.
  - On accept: counter loads N−1 (N=0 treated as 1); state goes to `MULTI`.
  - `ex_multi_busy` = accept this cycle OR state==`MULTI`.
- `MULTI`:
  - Counter decrements every cycle, including cycles where MEM stalls.
  - At count 0 the next state is `IDLE` and `ex_multi_done` pulses in that `IDLE` cycle.
  - `ex_multi_start` is ignored while in `MULTI`.
- Exception with `stallreq_mem`=0:
  - Same cycle: `flush`=1 and `new_pc`=`excp_new_pc`.
  - Counter clears, state goes to `IDLE`, no done pulse.
- Exception with `stallreq_mem`=1:
  - Latch the PC and go to `FLUSH_WAIT`; stall follows MEM priority.
  - In the first cycle with `stallreq_mem`=0: `flush`=1, `new_pc` = latched PC, then go to `IDLE`.
  - Further `excp_valid` in `FLUSH_WAIT` is ignored; the older exception wins.
- `new_pc` = 0 whenever `flush`=0.

## Timing
- Reset values: `stall`=0, `flush`=0, `new_pc`=0, `ex_multi_busy`=0, `ex_multi_done`=0; state `IDLE`; counter 0; latched PC 0.
- Reset asserted mid-operation: all state clears immediately and asynchronously, with no done pulse and no flush.
- Stall latency is 0 cycles from request.
- An undeferred flush has 0-cycle latency.
- Multi-cycle op started at cycle T:
  - `stall[3]` asserted for cycles T..T+N−1.
  - `ex_multi_done` pulses at T+N.
- Simultaneous `excp_valid` and `ex_multi_start`: the flush wins and the start is dropped.
- Simultaneous count expiry and flush: the flush wins and `ex_multi_done` is suppressed.
- Counter wrap is impossible: the load is bounded by `CntW`, and the counter decrements only while nonzero.

## Structure
- Shared `defines.vh` holds:
  - `StallBus`
  - stall pattern constants `STALL_NONE`, `STALL_IF`, `STALL_ID`, `STALL_EX`, `STALL_MEM`
  - state encodings
- Sub-module `multi_cycle_timer` holds the counter, `busy` and `done` logic, with inputs `start`, `len`, `cancel`.
- Top level holds:
  - the priority mux
  - the `FLUSH_WAIT` register and PC latch

## Test plan
- Independent requests, no exception:
  - `stallreq_id`=1 → `stall`=`00_0111`.
  - `stallreq_id`=1 plus `stallreq_mem`=1 → `01_1111`.
  - `stallreq_if`=1 alone → `00_0011`.
- Multi-cycle length: `ex_multi_start` with N=4 at T → `stall`=`00_1111` for T..T+3, `ex_multi_done` high only at T+4.
  - Repeat with N=0 → stall only at T, done at T+1.
- Undeferred exception: `excp_valid` with `excp_new_pc`=`0xBFC00380` while `stallreq_mem`=0 → same cycle `flush`=1, `new_pc`=`0xBFC00380`, `stall`=0.
- Deferred exception: `excp_valid` (PC `0xBFC00380`) with `stallreq_mem` held 3 cycles → `flush`=0 for those cycles, `stall`=`01_1111`.
  - Then one cycle `flush`=1 with the latched PC.
  - A second `excp_valid` (`0x80000000`) during the wait is ignored.
- Flush mid-multi: N=10 started at T, exception at T+3 → busy drops at T+3 and no `ex_multi_done` ever.
- Async reset during `MULTI` and during `FLUSH_WAIT` → all outputs 0 immediately; the next start behaves normally.

Source files
------------

// File: rtl/stall_sched_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
// Stall vector bits: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
package stall_sched_pkg;

  localparam int StallBus = 6;
  localparam int CntW     = 6;

  typedef logic [StallBus-1:0] stall_t;

  localparam stall_t STALL_NONE = 6'b00_0000;
  localparam stall_t STALL_IF   = 6'b00_0011;
  localparam stall_t STALL_ID   = 6'b00_0111;
  localparam stall_t STALL_EX   = 6'b00_1111;
  localparam stall_t STALL_MEM  = 6'b01_1111;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_MULTI      = 2'd1,
    ST_FLUSH_WAIT = 2'd2
  } sched_state_e;

  // The oldest (deepest) stage's request wins; a flush overrides every hold.
  function automatic stall_t stall_resolve(input logic flush, input logic mem,
                                           input logic ex, input logic id,
                                           input logic ifr);
    if (flush)    return STALL_NONE;
    else if (mem) return STALL_MEM;
    else if (ex)  return STALL_EX;
    else if (id)  return STALL_ID;
    else if (ifr) return STALL_IF;
    else          return STALL_NONE;
  endfunction

endpackage

// File: rtl/stall_sched_multi_cycle_timer.sv
// Down-counter sequencing multi-cycle EX operations; a nonzero count means
// the op is still running, and done pulses the cycle after the last busy cycle.
module multi_cycle_timer
  import stall_sched_pkg::*;
#(
  parameter int LenW = CntW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LenW-1:0] len,
  input  logic            cancel,
  output logic            busy,
  output logic            active,
  output logic            done
);

  logic [LenW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            accept;

  assign active = (cnt_q != '0);
  assign accept = start && !active && !cancel;
  assign busy   = !cancel && (accept || active);
  assign done   = done_q;

  // Load N-1 so a length of 0 or 1 never enters the running state.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (cancel) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d  = (len == '0) ? '0 : len - LenW'(1);
      done_d = (len <= LenW'(1));
    end else if (active) begin
      cnt_d  = cnt_q - LenW'(1);
      done_d = (cnt_q == LenW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/stall_sched.sv
// Pipeline stall/flush scheduler: priority stall merge, multi-cycle EX
// sequencing and exception flushes deferred behind in-flight MEM accesses.
module stall_sched
  import stall_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_if,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                stallreq_mem,
  input  logic                ex_multi_start,
  input  logic [CntW-1:0]     ex_multi_cycles,
  input  logic                excp_valid,
  input  logic [31:0]         excp_new_pc,
  output logic [StallBus-1:0] stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                ex_multi_busy,
  output logic                ex_multi_done
);

  // state_q only ever holds IDLE or FLUSH_WAIT; MULTI is the timer running.
  sched_state_e state_q, state_d, cur_st;
  logic [31:0]  pc_q, pc_d;
  logic         tmr_active, excp_take, cancel, start_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    cur_st = ST_IDLE;
    if (state_q == ST_FLUSH_WAIT) cur_st = ST_FLUSH_WAIT;
    else if (tmr_active)          cur_st = ST_MULTI;
  end

  always_comb begin
    state_d = ST_IDLE;
    pc_d    = pc_q;
    case (cur_st)
      ST_FLUSH_WAIT: begin
        if (stallreq_mem) state_d = ST_FLUSH_WAIT;
        else              pc_d    = '0;
      end
      default: begin
        if (excp_valid && stallreq_mem) begin
          state_d = ST_FLUSH_WAIT;
          pc_d    = excp_new_pc;
        end
      end
    endcase
  end

  // A latched exception ignores newer ones; the older one owns the flush.
  always_comb begin
    flush     = 1'b0;
    new_pc    = '0;
    excp_take = 1'b0;
    start_ok  = 1'b0;
    case (cur_st)
      ST_FLUSH_WAIT: begin
        flush  = !stallreq_mem;
        new_pc = flush ? pc_q : '0;
      end
      ST_MULTI: begin
        excp_take = excp_valid;
        flush     = excp_valid && !stallreq_mem;
        new_pc    = flush ? excp_new_pc : '0;
      end
      default: begin
        excp_take = excp_valid;
        flush     = excp_valid && !stallreq_mem;
        new_pc    = flush ? excp_new_pc : '0;
        start_ok  = !excp_valid && !stallreq_mem;
      end
    endcase
    cancel = flush || excp_take;
    stall  = stall_resolve(flush, stallreq_mem, stallreq_ex || ex_multi_busy,
                           stallreq_id, stallreq_if);
  end

  multi_cycle_timer #(.LenW(CntW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (ex_multi_start && start_ok),
    .len    (ex_multi_cycles),
    .cancel (cancel),
    .busy   (ex_multi_busy),
    .active (tmr_active),
    .done   (ex_multi_done)
  );

endmodule

// File: tb/tb_stall_sched.sv
// Randomized scoreboard bench for stall_sched against a cycle-timestamp model.
module tb_stall_sched;
  import stall_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        ex_multi_start;
  logic [5:0]  ex_multi_cycles;
  logic        excp_valid;
  logic [31:0] excp_new_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_multi_busy, ex_multi_done;

  stall_sched dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .ex_multi_start(ex_multi_start), .ex_multi_cycles(ex_multi_cycles),
    .excp_valid(excp_valid), .excp_new_pc(excp_new_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .ex_multi_busy(ex_multi_busy), .ex_multi_done(ex_multi_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Model: timestamps of the last busy cycle and of the done pulse.
  int          t = 0;
  int          busy_until = -1;
  int          done_at = -1;
  bit          pend = 0;
  logic [31:0] pend_pc = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s @%0t actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("flush", 32'(flush), 32'(e.flush));
      chk("new_pc", new_pc, e.pc);
      chk("busy", 32'(ex_multi_busy), 32'(e.busy));
      chk("done", 32'(ex_multi_done), 32'(e.done));
    end
  end

  task automatic cyc(input bit sif, input bit sid, input bit sex, input bit smem,
                     input bit sst, input int n, input bit ev, input logic [31:0] epc);
    exp_t e;
    bit in_multi, fl, take, cancel, accept, busy;
    int nn;
    @(posedge clk); #1;
    stallreq_if = sif; stallreq_id = sid; stallreq_ex = sex; stallreq_mem = smem;
    ex_multi_start = sst; ex_multi_cycles = 6'(n);
    excp_valid = ev; excp_new_pc = epc;
    in_multi = (t <= busy_until);
    fl       = pend ? !smem : (ev && !smem);
    take     = !pend && ev;
    cancel   = fl || take;
    accept   = sst && !in_multi && !pend && !cancel && !smem;
    busy     = !cancel && (accept || in_multi);
    e.done   = (t == done_at);
    e.busy   = busy;
    e.flush  = fl;
    e.pc     = fl ? (pend ? pend_pc : epc) : 32'h0;
    if (fl)                e.stall = 6'b00_0000;
    else if (smem)         e.stall = 6'b01_1111;
    else if (sex || busy)  e.stall = 6'b00_1111;
    else if (sid)          e.stall = 6'b00_0111;
    else if (sif)          e.stall = 6'b00_0011;
    else                   e.stall = 6'b00_0000;
    q.push_back(e);
    if (cancel) begin busy_until = -1; done_at = -1; end
    if (accept) begin
      nn = (n % 64 == 0) ? 1 : n % 64;
      busy_until = t + nn - 1;
      done_at    = t + nn;
    end
    if (pend && !smem) pend = 0;
    else if (!pend && ev && smem) begin pend = 1; pend_pc = epc; end
    t++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    ex_multi_start = 0; ex_multi_cycles = 0; excp_valid = 0; excp_new_pc = 0;
    #1 rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_busy", 32'(ex_multi_busy), 32'h0);
    chk("rst_done", 32'(ex_multi_done), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    busy_until = -1; done_at = -1; pend = 0; pend_pc = '0;
  endtask

  initial begin : stim
    rst = 1'b0;
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    ex_multi_start = 0; ex_multi_cycles = 0; excp_valid = 0; excp_new_pc = 0;
    #12;
    chk("init_stall", 32'(stall), 32'h0);
    chk("init_busy", 32'(ex_multi_busy), 32'h0);
    chk("init_done", 32'(ex_multi_done), 32'h0);
    #1 rst = 1'b1;

    // Independent requests
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    // Multi-cycle N=4 and N=0
    cyc(0, 0, 0, 0, 1, 4, 0, 0); idle(5);
    cyc(0, 0, 0, 0, 1, 0, 0, 0); idle(2);
    // Undeferred exception
    cyc(0, 1, 0, 0, 0, 0, 1, 32'hBFC0_0380); idle(1);
    // Deferred exception, second exception ignored
    cyc(0, 0, 0, 1, 0, 0, 1, 32'hBFC0_0380);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, 32'h8000_0000);
    cyc(0, 0, 0, 0, 0, 0, 0, 0); idle(1);
    // Flush mid-multi
    cyc(0, 0, 0, 0, 1, 10, 0, 0); idle(2);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678); idle(12);
    // Expiry coincident with flush; start coincident with exception
    cyc(0, 0, 0, 0, 1, 3, 0, 0); idle(1);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h0000_0100); idle(3);
    cyc(0, 0, 0, 0, 1, 5, 1, 32'h0000_0200); idle(2);
    // Multi op running across MEM stalls
    cyc(0, 0, 0, 0, 1, 3, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0); cyc(0, 0, 0, 1, 0, 0, 0, 0); idle(2);
    // Async reset during MULTI and during FLUSH_WAIT
    cyc(0, 0, 0, 0, 1, 10, 0, 0); idle(2);
    do_reset();
    cyc(0, 0, 0, 0, 1, 3, 0, 0); idle(4);
    cyc(0, 0, 0, 1, 0, 0, 1, 32'hBFC0_0380); cyc(0, 0, 0, 1, 0, 0, 0, 0);
    do_reset();
    idle(1); cyc(0, 0, 0, 0, 1, 2, 0, 0); idle(4);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0,
          ($urandom_range(0, 15) == 0) ? 63 : int'($urandom_range(0, 12)),
          $urandom_range(0, 11) == 0, $urandom);
    end
    idle(2);
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
